alu_req_rsp: RTL and testbench



---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_cmd_fifo.sv | 69 ++++++
 rtl/alu_req_rsp.sv | 212 +++++++++++++++++++++
 tb/tb_alu_req_rsp.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg (package)
//  Description : Shared definitions for the ALU request/response slice:
//                controller state encoding, default operand/select widths,
//                ALU opcode constants and a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int c_def_width = 20;
    localparam int c_def_sel_w = 3;

    // Operation codes understood by the external combinational ALU
    localparam logic [2:0] c_op_add = 3'b001;
    localparam logic [2:0] c_op_sub = 3'b010;
    localparam logic [2:0] c_op_and = 3'b011;
    localparam logic [2:0] c_op_or  = 3'b100;
    localparam logic [2:0] c_op_xor = 3'b101;
    localparam logic [2:0] c_op_shl = 3'b110;
    localparam logic [2:0] c_op_shr = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } alu_state_t;

    // Width of a down-counter that is loaded with (settle - 1)
    function automatic int cnt_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_fifo
//  Description : Synchronous command FIFO, DATA_W wide, DEPTH entries
//                (power of two, >= 2). Pointers carry one extra bit so that
//                full and empty are distinguished without a counter.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                push, push_data - write request / data (ignored when full)
//                pop             - read request (ignored when empty)
//                pop_data        - head entry (valid when !empty)
//                full, empty     - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo #(
    parameter int DATA_W = 43,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int c_addr_w = $clog2(DEPTH);

    logic [c_addr_w:0]   r_wr_ptr;
    logic [c_addr_w:0]   r_rd_ptr;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_push_ok;
    logic                w_pop_ok;

    // A full FIFO refuses the push even if a pop happens in the same cycle,
    // so no entry is ever overwritten.
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                   (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);

    assign pop_data = r_mem[r_rd_ptr[c_addr_w-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: contents are only observed through the pointers.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_req_rsp.sv
`default_nettype none
// ============================================================================
//  Module      : alu_req_rsp
//  Description : Request/response wrapper around an external combinational
//                ALU. Commands are queued in a FIFO and issued one at a time:
//                operands are registered onto alu_a/alu_b/alu_sel, allowed to
//                settle for SETTLE cycles, and the result is captured into
//                rsp_data and held until the consumer accepts it.
//  Ports       : clk, rst_n                       - clock, async active-low reset
//                req_valid/req_ready, req_a/b/sel - command channel
//                alu_a/alu_b/alu_sel, alu_c       - external ALU interface
//                rsp_valid/rsp_ready, rsp_data    - response channel
//                rsp_zero                         - result-is-zero flag (only
//                                                   with the macro below)
//  Options     : `define ALU_REQ_RSP_ZERO_FLAG_EN adds the rsp_zero output.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_req_rsp
    import alu_pkg::*;
#(
    parameter int WIDTH  = c_def_width,
    parameter int SEL_W  = c_def_sel_w,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [SEL_W-1:0] req_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_c,
    output logic             rsp_valid,
    input  logic             rsp_ready,
`ifdef ALU_REQ_RSP_ZERO_FLAG_EN
    output logic             rsp_zero,
`endif
    output logic [WIDTH-1:0] rsp_data
);

    localparam int c_cmd_w = 2 * WIDTH + SEL_W;
    localparam int c_cnt_w = cnt_width(SETTLE);
    localparam logic [c_cnt_w-1:0] c_settle_init = c_cnt_w'(SETTLE - 1);

    alu_state_t         r_state;
    alu_state_t         w_state_nxt;

    logic               r_init_done;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [SEL_W-1:0]   r_alu_sel;
    logic [WIDTH-1:0]   r_rsp_data;
    logic               r_rsp_valid;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_cnt_dec;
    logic               w_capture;
    logic               w_release;
    logic [c_cmd_w-1:0] w_push_data;
    logic [c_cmd_w-1:0] w_head;

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    // req_ready stays low during reset and rises on the first edge after
    // release, so a sender cannot push into a FIFO still held in reset.
    assign req_ready   = r_init_done & ~w_full;
    assign w_push      = req_valid & req_ready;
    assign w_push_data = {req_a, req_b, req_sel};

    alu_cmd_fifo #(
        .DATA_W (c_cmd_w),
        .DEPTH  (DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Controller: next state and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_cnt_dec   = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_CAPTURE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                // rsp_valid is always high in this state
                if (rsp_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: ALU operand registers and settle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_pop) begin
                r_alu_a   <= w_head[c_cmd_w-1 -: WIDTH];
                r_alu_b   <= w_head[SEL_W +: WIDTH];
                r_alu_sel <= w_head[SEL_W-1:0];
                r_cnt     <= c_settle_init;
            end else if (w_cnt_dec) begin
                r_cnt     <= r_cnt - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath: response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_capture) begin
                r_rsp_data  <= alu_c;
                r_rsp_valid <= 1'b1;
            end else if (w_release) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_REQ_RSP_ZERO_FLAG_EN
    logic r_rsp_zero;

    // Captured on the same edge as rsp_data so the two always agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_zero <= 1'b0;
        end else if (w_capture) begin
            r_rsp_zero <= (alu_c == '0);
        end
    end

    assign rsp_zero = r_rsp_zero;
`endif

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign rsp_data  = r_rsp_data;
    assign rsp_valid = r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_req_rsp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_req_rsp
//  Description : Self-checking bench for alu_req_rsp (default parameters).
//                Models the external ALU, applies a table of directed
//                vectors, then hand-written back-pressure, hold and
//                mid-operation reset sequences.
//  Options     : honours ALU_REQ_RSP_ZERO_FLAG_EN for the rsp_zero output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_req_rsp;
    import alu_pkg::*;

    localparam int W = 20;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic [2:0]    req_sel;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [2:0]    alu_sel;
    logic [W-1:0]  alu_c;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
`ifdef ALU_REQ_RSP_ZERO_FLAG_EN
    logic          rsp_zero;
`endif

    int total = 0;
    int bad   = 0;

    alu_req_rsp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_c     (alu_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
`ifdef ALU_REQ_RSP_ZERO_FLAG_EN
        .rsp_zero  (rsp_zero),
`endif
        .rsp_data  (rsp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External combinational ALU
    always_comb begin
        case (alu_sel)
            c_op_add: alu_c = alu_a + alu_b;
            c_op_sub: alu_c = alu_a - alu_b;
            c_op_and: alu_c = alu_a & alu_b;
            c_op_or:  alu_c = alu_a | alu_b;
            c_op_xor: alu_c = alu_a ^ alu_b;
            c_op_shl: alu_c = alu_a << alu_b[4:0];
            c_op_shr: alu_c = alu_a >> alu_b[4:0];
            default:  alu_c = '0;
        endcase
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   sel;
        logic [W-1:0] exp;
        logic         exp_zero;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic send_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2:0] sel, input int budget, output bit accepted);
        accepted  = 1'b0;
        req_a     = a;
        req_b     = b;
        req_sel   = sel;
        req_valid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (req_ready) begin
                tick();
                accepted = 1'b1;
                break;
            end
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output int cycles, output bit got);
        got    = 1'b0;
        cycles = 0;
        while (cycles < budget && !got) begin
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                tick();
                cycles++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        bit got;
        int cyc;
        int n_acc;
        int seen;
        logic [W-1:0] order_exp [5];

        vecs[0]  = '{20'd8,       20'd4,  c_op_add, 20'd12,      1'b0};
        vecs[1]  = '{20'd12,      20'd3,  c_op_sub, 20'd9,       1'b0};
        vecs[2]  = '{20'd4,       20'd8,  c_op_and, 20'd0,       1'b1};
        vecs[3]  = '{20'd12,      20'd4,  c_op_or,  20'd12,      1'b0};
        vecs[4]  = '{20'd28,      20'd72, c_op_xor, 20'd84,      1'b0};
        vecs[5]  = '{20'd3,       20'd5,  c_op_sub, 20'hFFFFE,   1'b0};
        vecs[6]  = '{20'hFFFFF,   20'd1,  c_op_add, 20'd0,       1'b1};
        vecs[7]  = '{20'd1,       20'd19, c_op_shl, 20'h80000,   1'b0};
        vecs[8]  = '{20'h80000,   20'd19, c_op_shr, 20'd1,       1'b0};
        vecs[9]  = '{20'd3,       20'd4,  c_op_shl, 20'd48,      1'b0};
        vecs[10] = '{20'd4,       20'd4,  c_op_sub, 20'd0,       1'b1};
        vecs[11] = '{20'd5,       20'd4,  c_op_sub, 20'd1,       1'b0};

        order_exp[0] = 20'd12;
        order_exp[1] = 20'd9;
        order_exp[2] = 20'd0;
        order_exp[3] = 20'd12;
        order_exp[4] = 20'd84;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        rsp_ready = 1'b1;

        // ---------------- reset values ----------------
        @(posedge clk);
        #1;
        check("rst_alu_a",     32'(alu_a),     32'd0);
        check("rst_alu_b",     32'(alu_b),     32'd0);
        check("rst_alu_sel",   32'(alu_sel),   32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
`ifdef ALU_REQ_RSP_ZERO_FLAG_EN
        check("rst_rsp_zero",  32'(rsp_zero),  32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(req_ready), 32'd0);
        tick();
        check("ready_after_edge", 32'(req_ready), 32'd1);

        // ---------------- table-driven single commands ----------------
        for (int i = 0; i < 12; i++) begin
            send_cmd(vecs[i].a, vecs[i].b, vecs[i].sel, 10, acc);
            check($sformatf("vec%0d_accept", i), 32'(acc), 32'd1);
            wait_rsp(20, cyc, got);
            check($sformatf("vec%0d_latency", i), 32'(cyc), 32'd3);
            check($sformatf("vec%0d_data", i), 32'(rsp_data), 32'(vecs[i].exp));
`ifdef ALU_REQ_RSP_ZERO_FLAG_EN
            check($sformatf("vec%0d_zero", i), 32'(rsp_zero), 32'(vecs[i].exp_zero));
`endif
            tick();
            check($sformatf("vec%0d_drop", i), 32'(rsp_valid), 32'd0);
        end

        // ---------------- back-pressure: 6 commands, 5 accepted ----------------
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 6; k++) begin
            if (k < 5) begin
                send_cmd(vecs[k].a, vecs[k].b, vecs[k].sel, 6, acc);
            end else begin
                send_cmd(vecs[9].a, vecs[9].b, vecs[9].sel, 6, acc);
            end
            if (acc) n_acc++;
        end
        check("bp_accepted", 32'(n_acc), 32'd5);
        check("bp_req_ready_low", 32'(req_ready), 32'd0);
        check("bp_first_waiting", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            wait_rsp(20, cyc, got);
            check($sformatf("bp_rsp%0d_valid", r), 32'(got), 32'd1);
            check($sformatf("bp_rsp%0d_data", r), 32'(rsp_data), 32'(order_exp[r]));
            tick();
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) seen++;
            tick();
        end
        check("bp_no_extra_rsp", 32'(seen), 32'd0);
        check("bp_ready_back", 32'(req_ready), 32'd1);

        // ---------------- hold during RESP ----------------
        rsp_ready = 1'b0;
        send_cmd(vecs[1].a, vecs[1].b, vecs[1].sel, 10, acc);
        wait_rsp(20, cyc, got);
        check("hold_got", 32'(got), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("hold%0d", i), {11'd0, rsp_valid, rsp_data}, {11'd0, 1'b1, 20'd9});
            check($sformatf("hold%0d_alu_a", i), 32'(alu_a), 32'd12);
        end
        rsp_ready = 1'b1;
        tick();
        check("hold_release", 32'(rsp_valid), 32'd0);

        // ---------------- reset while in SETTLE with 2 queued ----------------
        rsp_ready = 1'b0;
        send_cmd(vecs[0].a, vecs[0].b, vecs[0].sel, 10, acc);
        wait_rsp(20, cyc, got);
        send_cmd(vecs[3].a, vecs[3].b, vecs[3].sel, 10, acc);
        send_cmd(vecs[4].a, vecs[4].b, vecs[4].sel, 10, acc);
        send_cmd(vecs[7].a, vecs[7].b, vecs[7].sel, 10, acc);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        check("mid_loaded_a", 32'(alu_a), 32'd12);
        check("mid_loaded_sel", 32'(alu_sel), 32'(c_op_or));
        rst_n = 1'b0;
        #1;
        check("mid_rst_alu_a",     32'(alu_a),     32'd0);
        check("mid_rst_alu_b",     32'(alu_b),     32'd0);
        check("mid_rst_alu_sel",   32'(alu_sel),   32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_data",  32'(rsp_data),  32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_ready_before_edge", 32'(req_ready), 32'd0);
        tick();
        check("mid_ready_after_edge", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) seen++;
            tick();
        end
        check("mid_no_stale_rsp", 32'(seen), 32'd0);
        send_cmd(vecs[8].a, vecs[8].b, vecs[8].sel, 10, acc);
        wait_rsp(20, cyc, got);
        check("mid_new_latency", 32'(cyc), 32'd3);
        check("mid_new_data", 32'(rsp_data), 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
